// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle CPU control FSM with memory handshake, timeout trap and retired counter.
// Moore outputs from the registered state; only irWe/pcWe/mdrWe (memAck) and branch pcWe (eq) see inputs.
module mc_ctrl_fsm #(
    parameter int CMD_W       = 4,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CMD_W-1:0] cmd,
    input  logic             eq,
    input  logic             memAck,
    output logic             memReq,
    output logic             memWe,
    output logic             memIn,
    output logic             irWe,
    output logic             mdrWe,
    output logic             aWe,
    output logic             bWe,
    output logic             pcWe,
    output logic             regWe,
    output logic [1:0]       pcSrc,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [2:0]       aluOp,
    output logic [1:0]       dst,
    output logic [1:0]       regIn,
    output logic             trap,
    output logic [1:0]       trapCause,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_BRANCH, S_JUMP, S_JAL, S_JR, S_EX_R, S_EX_I,
        S_EX_ADDR, S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_I, S_WB_LW, S_TRAP
    } state_t;

    localparam logic [CMD_W-1:0] C_LW   = CMD_W'(0);
    localparam logic [CMD_W-1:0] C_SW   = CMD_W'(1);
    localparam logic [CMD_W-1:0] C_J    = CMD_W'(2);
    localparam logic [CMD_W-1:0] C_JR   = CMD_W'(3);
    localparam logic [CMD_W-1:0] C_JAL  = CMD_W'(4);
    localparam logic [CMD_W-1:0] C_BEQ  = CMD_W'(5);
    localparam logic [CMD_W-1:0] C_BNE  = CMD_W'(6);
    localparam logic [CMD_W-1:0] C_XORI = CMD_W'(7);
    localparam logic [CMD_W-1:0] C_ADDI = CMD_W'(8);
    localparam logic [CMD_W-1:0] C_ADD  = CMD_W'(9);
    localparam logic [CMD_W-1:0] C_SUB  = CMD_W'(10);
    localparam logic [CMD_W-1:0] C_SLT  = CMD_W'(11);

    state_t           state_q, state_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_st, timeout;

    assign mem_st  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout = (MEM_TIMEOUT != 0) && mem_st && !memAck && (wait_q == TO_W'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            cause_q   <= 2'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH:   state_d = memAck ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (cmd)
                    C_BEQ, C_BNE:        state_d = S_BRANCH;
                    C_J:                 state_d = S_JUMP;
                    C_JAL:               state_d = S_JAL;
                    C_JR:                state_d = S_JR;
                    C_ADD, C_SUB, C_SLT: state_d = S_EX_R;
                    C_XORI, C_ADDI:      state_d = S_EX_I;
                    C_LW, C_SW:          state_d = S_EX_ADDR;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'd1;
                    end
                endcase
            end
            S_EX_R:    state_d = S_WB_R;
            S_EX_I:    state_d = S_WB_I;
            S_EX_ADDR: state_d = (cmd == C_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  state_d = memAck ? S_WB_LW : S_MEM_RD;
            S_MEM_WR:  state_d = memAck ? S_FETCH : S_MEM_WR;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
        if (timeout) begin
            state_d = S_TRAP;
            cause_d = 2'd2;
        end
        // Any state change restarts the wait count; only memory states ever stay put.
        wait_d    = (state_d != state_q) ? '0 : (mem_st && !memAck) ? wait_q + TO_W'(1) : wait_q;
        retired_d = retired_q + CNT_W'(state_d == S_FETCH && state_q != S_FETCH);
    end

    always_comb begin
        memReq  = 1'b0;
        memWe   = 1'b0;
        memIn   = 1'b0;
        irWe    = 1'b0;
        mdrWe   = 1'b0;
        aWe     = 1'b0;
        bWe     = 1'b0;
        pcWe    = 1'b0;
        regWe   = 1'b0;
        pcSrc   = 2'd0;
        aluSrcA = 1'b0;
        aluSrcB = 2'd0;
        aluOp   = 3'd0;
        dst     = 2'd0;
        regIn   = 2'd0;
        case (state_q)
            S_FETCH: begin
                memReq  = 1'b1;
                aluSrcB = 2'd3;
                pcSrc   = 2'd1;
                irWe    = memAck;
                pcWe    = memAck;
            end
            S_DECODE: begin
                aWe = 1'b1;
                bWe = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'd2;
                aluOp   = 3'd1;
                pcWe    = (cmd == C_BNE) ? !eq : eq;
            end
            S_JUMP: begin
                pcSrc = 2'd2;
                pcWe  = 1'b1;
            end
            S_JAL: begin
                pcSrc = 2'd2;
                pcWe  = 1'b1;
                regWe = 1'b1;
                dst   = 2'd2;
                regIn = 2'd2;
            end
            S_JR: begin
                pcSrc = 2'd3;
                pcWe  = 1'b1;
            end
            S_EX_R: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'd2;
                aluOp   = (cmd == C_SUB) ? 3'd1 : (cmd == C_SLT) ? 3'd3 : 3'd0;
            end
            S_EX_I: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'd1;
                aluOp   = (cmd == C_XORI) ? 3'd2 : 3'd0;
            end
            S_EX_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'd1;
            end
            S_MEM_RD: begin
                memReq = 1'b1;
                memIn  = 1'b1;
                mdrWe  = memAck;
            end
            S_MEM_WR: begin
                memReq = 1'b1;
                memWe  = 1'b1;
                memIn  = 1'b1;
            end
            S_WB_R: begin
                regWe = 1'b1;
                regIn = 2'd1;
            end
            S_WB_I: begin
                regWe = 1'b1;
                dst   = 2'd1;
                regIn = 2'd1;
            end
            S_WB_LW: begin
                regWe = 1'b1;
                dst   = 2'd1;
            end
            default: ;
        endcase
    end

    assign trap      = (state_q == S_TRAP);
    assign trapCause = cause_q;
    assign retired   = retired_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven cycle-by-cycle check of mc_ctrl_fsm outputs and retired count.
module tb_mc_ctrl_fsm;
    typedef struct packed {
        logic req, we, min, ir, mdr, a, b, pc, rg;
        logic [1:0] pcs;
        logic asa;
        logic [1:0] asb;
        logic [2:0] op;
        logic [1:0] dst, rin;
        logic trap;
        logic [1:0] cause;
    } outs_t;

    typedef struct {
        logic rst;
        logic [3:0] cmd;
        logic eq, ack;
        outs_t exp;
        logic [31:0] ret;
    } vec_t;

    localparam outs_t F0      = '{req:1'b1, pcs:2'd1, asb:2'd3, default:'0};
    localparam outs_t F1      = '{req:1'b1, ir:1'b1, pc:1'b1, pcs:2'd1, asb:2'd3, default:'0};
    localparam outs_t DEC     = '{a:1'b1, b:1'b1, default:'0};
    localparam outs_t BR0     = '{asa:1'b1, asb:2'd2, op:3'd1, default:'0};
    localparam outs_t BR1     = '{pc:1'b1, asa:1'b1, asb:2'd2, op:3'd1, default:'0};
    localparam outs_t JALO    = '{pc:1'b1, pcs:2'd2, rg:1'b1, dst:2'd2, rin:2'd2, default:'0};
    localparam outs_t JO      = '{pc:1'b1, pcs:2'd2, default:'0};
    localparam outs_t JRO     = '{pc:1'b1, pcs:2'd3, default:'0};
    localparam outs_t EXR_ADD = '{asa:1'b1, asb:2'd2, default:'0};
    localparam outs_t EXR_SUB = '{asa:1'b1, asb:2'd2, op:3'd1, default:'0};
    localparam outs_t EXR_SLT = '{asa:1'b1, asb:2'd2, op:3'd3, default:'0};
    localparam outs_t EXI_X   = '{asa:1'b1, asb:2'd1, op:3'd2, default:'0};
    localparam outs_t EXA     = '{asa:1'b1, asb:2'd1, default:'0};
    localparam outs_t MR0     = '{req:1'b1, min:1'b1, default:'0};
    localparam outs_t MR1     = '{req:1'b1, min:1'b1, mdr:1'b1, default:'0};
    localparam outs_t MW0     = '{req:1'b1, we:1'b1, min:1'b1, default:'0};
    localparam outs_t WBR     = '{rg:1'b1, rin:2'd1, default:'0};
    localparam outs_t WBI     = '{rg:1'b1, dst:2'd1, rin:2'd1, default:'0};
    localparam outs_t WBL     = '{rg:1'b1, dst:2'd1, default:'0};
    localparam outs_t TRAP1   = '{trap:1'b1, cause:2'd1, default:'0};
    localparam outs_t TRAP2   = '{trap:1'b1, cause:2'd2, default:'0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, eq = 1'b0, memAck = 1'b0;
    logic [3:0] cmd = 4'd9;
    logic memReq, memWe, memIn, irWe, mdrWe, aWe, bWe, pcWe, regWe, aluSrcA, trap;
    logic [1:0] pcSrc, aluSrcB, dst, regIn, trapCause;
    logic [2:0] aluOp;
    logic [31:0] retired;

    logic reset2 = 1'b1, memAck2 = 1'b0;
    logic [3:0] cmd2 = 4'd9;
    logic memReq2, memWe2, memIn2, irWe2, mdrWe2, aWe2, bWe2, pcWe2, regWe2, aluSrcA2, trap2;
    logic [1:0] pcSrc2, aluSrcB2, dst2, regIn2, trapCause2;
    logic [2:0] aluOp2;
    logic [31:0] retired2;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .cmd(cmd), .eq(eq), .memAck(memAck),
        .memReq(memReq), .memWe(memWe), .memIn(memIn), .irWe(irWe), .mdrWe(mdrWe),
        .aWe(aWe), .bWe(bWe), .pcWe(pcWe), .regWe(regWe), .pcSrc(pcSrc),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .dst(dst), .regIn(regIn),
        .trap(trap), .trapCause(trapCause), .retired(retired)
    );

    mc_ctrl_fsm #(.MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset2), .cmd(cmd2), .eq(1'b0), .memAck(memAck2),
        .memReq(memReq2), .memWe(memWe2), .memIn(memIn2), .irWe(irWe2), .mdrWe(mdrWe2),
        .aWe(aWe2), .bWe(bWe2), .pcWe(pcWe2), .regWe(regWe2), .pcSrc(pcSrc2),
        .aluSrcA(aluSrcA2), .aluSrcB(aluSrcB2), .aluOp(aluOp2), .dst(dst2), .regIn(regIn2),
        .trap(trap2), .trapCause(trapCause2), .retired(retired2)
    );

    outs_t got, got2;
    assign got  = {memReq, memWe, memIn, irWe, mdrWe, aWe, bWe, pcWe, regWe, pcSrc,
                   aluSrcA, aluSrcB, aluOp, dst, regIn, trap, trapCause};
    assign got2 = {memReq2, memWe2, memIn2, irWe2, mdrWe2, aWe2, bWe2, pcWe2, regWe2, pcSrc2,
                   aluSrcA2, aluSrcB2, aluOp2, dst2, regIn2, trap2, trapCause2};

    int n_cmp = 0, n_bad = 0;
    vec_t tbl[$];

    function automatic vec_t v(logic r, logic [3:0] c, logic e, logic a, outs_t x, int ret);
        vec_t t;
        t.rst = r; t.cmd = c; t.eq = e; t.ack = a; t.exp = x; t.ret = 32'(ret);
        return t;
    endfunction

    task automatic step(input bit second, input vec_t t, input string nm);
        outs_t o;
        logic [31:0] r;
        @(negedge clk);
        if (second) begin
            reset2 = t.rst; cmd2 = t.cmd; memAck2 = t.ack;
        end else begin
            reset = t.rst; cmd = t.cmd; eq = t.eq; memAck = t.ack;
        end
        #1;
        o = second ? got2 : got;
        r = second ? retired2 : retired;
        n_cmp++;
        if (o !== t.exp) begin
            n_bad++;
            $display("FAIL %s outputs: got %h want %h", nm, o, t.exp);
        end
        n_cmp++;
        if (r !== t.ret) begin
            n_bad++;
            $display("FAIL %s retired: got %0d want %0d", nm, r, t.ret);
        end
    endtask

    initial begin
        tbl.push_back(v(1, 9, 0, 0, F0, 0));
        // ADD, single-cycle acks
        tbl.push_back(v(0, 9, 0, 1, F1, 0));
        tbl.push_back(v(0, 9, 0, 1, DEC, 0));
        tbl.push_back(v(0, 9, 0, 1, EXR_ADD, 0));
        tbl.push_back(v(0, 9, 0, 1, WBR, 0));
        // LW with three wait states in MEM_RD
        tbl.push_back(v(0, 0, 0, 1, F1, 1));
        tbl.push_back(v(0, 0, 0, 1, DEC, 1));
        tbl.push_back(v(0, 0, 0, 1, EXA, 1));
        tbl.push_back(v(0, 0, 0, 0, MR0, 1));
        tbl.push_back(v(0, 0, 0, 0, MR0, 1));
        tbl.push_back(v(0, 0, 0, 0, MR0, 1));
        tbl.push_back(v(0, 0, 0, 1, MR1, 1));
        tbl.push_back(v(0, 0, 0, 1, WBL, 1));
        // BEQ not taken, BNE taken
        tbl.push_back(v(0, 5, 0, 1, F1, 2));
        tbl.push_back(v(0, 5, 0, 1, DEC, 2));
        tbl.push_back(v(0, 5, 0, 1, BR0, 2));
        tbl.push_back(v(0, 6, 0, 1, F1, 3));
        tbl.push_back(v(0, 6, 0, 1, DEC, 3));
        tbl.push_back(v(0, 6, 0, 1, BR1, 3));
        // JAL, J, JR
        tbl.push_back(v(0, 4, 0, 1, F1, 4));
        tbl.push_back(v(0, 4, 0, 1, DEC, 4));
        tbl.push_back(v(0, 4, 0, 1, JALO, 4));
        tbl.push_back(v(0, 2, 0, 1, F1, 5));
        tbl.push_back(v(0, 2, 0, 1, DEC, 5));
        tbl.push_back(v(0, 2, 0, 1, JO, 5));
        tbl.push_back(v(0, 3, 0, 1, F1, 6));
        tbl.push_back(v(0, 3, 0, 1, DEC, 6));
        tbl.push_back(v(0, 3, 0, 1, JRO, 6));
        // XORI
        tbl.push_back(v(0, 7, 0, 1, F1, 7));
        tbl.push_back(v(0, 7, 0, 1, DEC, 7));
        tbl.push_back(v(0, 7, 0, 1, EXI_X, 7));
        tbl.push_back(v(0, 7, 0, 1, WBI, 7));
        // SW with one wait state in FETCH and MEM_WR
        tbl.push_back(v(0, 1, 0, 0, F0, 8));
        tbl.push_back(v(0, 1, 0, 1, F1, 8));
        tbl.push_back(v(0, 1, 0, 1, DEC, 8));
        tbl.push_back(v(0, 1, 0, 1, EXA, 8));
        tbl.push_back(v(0, 1, 0, 0, MW0, 8));
        tbl.push_back(v(0, 1, 0, 1, MW0, 8));
        // SUB, SLT
        tbl.push_back(v(0, 10, 0, 1, F1, 9));
        tbl.push_back(v(0, 10, 0, 1, DEC, 9));
        tbl.push_back(v(0, 10, 0, 1, EXR_SUB, 9));
        tbl.push_back(v(0, 10, 0, 1, WBR, 9));
        tbl.push_back(v(0, 11, 0, 1, F1, 10));
        tbl.push_back(v(0, 11, 0, 1, DEC, 10));
        tbl.push_back(v(0, 11, 0, 1, EXR_SLT, 10));
        tbl.push_back(v(0, 11, 0, 1, WBR, 10));
        // LW aborted by reset while waiting in MEM_RD
        tbl.push_back(v(0, 0, 0, 1, F1, 11));
        tbl.push_back(v(0, 0, 0, 1, DEC, 11));
        tbl.push_back(v(0, 0, 0, 1, EXA, 11));
        tbl.push_back(v(0, 0, 0, 0, MR0, 11));
        tbl.push_back(v(1, 0, 0, 0, MR0, 11));
        tbl.push_back(v(0, 5, 0, 0, F0, 0));
        // BEQ taken
        tbl.push_back(v(0, 5, 1, 1, F1, 0));
        tbl.push_back(v(0, 5, 1, 1, DEC, 0));
        tbl.push_back(v(0, 5, 1, 1, BR1, 0));
        // illegal command traps and holds regardless of inputs
        tbl.push_back(v(0, 13, 0, 1, F1, 1));
        tbl.push_back(v(0, 13, 0, 1, DEC, 1));
        for (int i = 0; i < 10; i++) tbl.push_back(v(0, 13, i[0], ~i[0], TRAP1, 1));
        tbl.push_back(v(1, 13, 0, 1, TRAP1, 1));
        tbl.push_back(v(0, 9, 0, 0, F0, 0));

        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) step(1'b0, tbl[i], $sformatf("row%0d", i));

        // timeout DUT: five unacknowledged FETCH cycles, then TRAP with cause 2
        for (int i = 0; i < 5; i++) step(1'b1, v(0, 9, 0, 0, F0, 0), $sformatf("to_fetch%0d", i));
        for (int i = 0; i < 3; i++) step(1'b1, v(0, 9, 0, 0, TRAP2, 0), $sformatf("to_trap%0d", i));
        step(1'b1, v(1, 9, 0, 0, TRAP2, 0), "to_reset");
        // ack arriving in the timeout cycle wins
        for (int i = 0; i < 4; i++) step(1'b1, v(0, 9, 0, 0, F0, 0), $sformatf("to_wait%0d", i));
        step(1'b1, v(0, 9, 0, 1, F1, 0), "to_ack_wins");
        step(1'b1, v(0, 9, 0, 0, DEC, 0), "to_decode");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Parametrised successor to the multicycle CPU control FSM.
- Adds a memory request/acknowledge handshake with variable wait states and a memory timeout.
- Adds full JAL support (link write to R31), an illegal-command trap and a retired-instruction counter.
- Sits between the instruction decoder (cmd) and the multicycle datapath; all datapath enables come from here.

Parameters:
- CMD_W, 4, width of decoded command input.
- CNT_W, 32, width of retired-instruction counter.
- MEM_TIMEOUT, 255, max cycles waiting for memAck before trap; 0 disables the timeout.
- TO_W, 8, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  synchronous active-high reset.
- cmd  in  CMD_W  decoded command of current IR: LW0 SW1 J2 JR3 JAL4 BEQ5 BNE6 XORI7 ADDI8 ADD9 SUB10 SLT11; 12..15 illegal.
- eq  in  1  ALU zero flag, valid in BRANCH state.
- memAck  in  1  memory completes the current request this cycle.
- memReq  out  1  memory request active.
- memWe  out  1  write request (qualified by memReq).
- memIn  out  1  address select: 0 PC, 1 ALU result.
- irWe, mdrWe, aWe, bWe, pcWe, regWe  out  1 each  register write enables.
- pcSrc  out  2  0 ALU result reg, 1 ALU, 2 jump target, 3 A.
- aluSrcA  out  1  0 PC, 1 A.
- aluSrcB  out  2  0 sign-ext imm shifted, 1 sign-ext imm, 2 B, 3 constant 4.
- aluOp  out  3  0 ADD, 1 SUB, 2 XOR, 3 SLT.
- dst  out  2  0 rd, 1 rt, 2 R31.
- regIn  out  2  0 MDR, 1 ALU result, 2 PC.
- trap  out  1  FSM halted in TRAP.
- trapCause  out  2  0 none, 1 illegal cmd, 2 memory timeout.
- retired  out  CNT_W  completed-instruction count.

Behaviour:
- Output style: outputs decoded combinationally from the registered state (Moore). Exceptions: enables gated by memAck or eq, as noted.
- Default for every output: 0, including all enables, memReq and the mux selects.
- Reset: state=FETCH, wait counter=0, retired=0, trap=0, trapCause=0. Reset overrides everything, including a request in flight, and is also the only exit from TRAP.
- FETCH: memReq=1, memIn=0, aluSrcA=0, aluSrcB=3, aluOp=ADD, pcSrc=1.
  - irWe=pcWe=memAck.
  - On memAck go to DECODE.
- DECODE: aWe=bWe=1, aluSrcA=0, aluSrcB=0, aluOp=ADD (branch target latched into the ALU result reg). Next state by cmd:
  - BEQ/BNE -> BRANCH; J -> JUMP; JAL -> JAL; JR -> JR.
  - ADD/SUB/SLT -> EX_R; XORI/ADDI -> EX_I; LW/SW -> EX_ADDR.
  - Illegal -> TRAP with cause 1.
- BRANCH: aluSrcA=1, aluSrcB=2, aluOp=SUB, pcSrc=0, pcWe = eq for BEQ, !eq for BNE. Next FETCH.
- JUMP: pcSrc=2, pcWe=1. Next FETCH.
- JAL: pcSrc=2, pcWe=1, regWe=1, dst=2, regIn=2 (links the already-incremented PC). Next FETCH.
- JR: pcSrc=3, pcWe=1. Next FETCH.
- EX_R: aluSrcA=1, aluSrcB=2, aluOp ADD/SUB/SLT per cmd. Next WB_R.
- EX_I: aluSrcA=1, aluSrcB=1, aluOp XOR for XORI, ADD for ADDI. Next WB_I.
- EX_ADDR: aluSrcA=1, aluSrcB=1, aluOp=ADD. Next MEM_RD for LW, MEM_WR for SW.
- MEM_RD: memReq=1, memIn=1, mdrWe=memAck. On ack go to WB_LW.
- MEM_WR: memReq=1, memWe=1, memIn=1. On ack go to FETCH.
- WB_R: regWe=1, dst=0, regIn=1. Next FETCH.
- WB_I: regWe=1, dst=1, regIn=1. Next FETCH.
- WB_LW: regWe=1, dst=1, regIn=0. Next FETCH.
- TRAP: all enables and memReq 0, trap=1. State held until reset.
- Wait counter:
  - Cleared on entry to any memory state (FETCH, MEM_RD, MEM_WR).
  - Increments each cycle in that state without memAck.
  - If MEM_TIMEOUT!=0, counter==MEM_TIMEOUT and memAck=0 -> TRAP with cause 2.
  - memAck in the timeout cycle wins (no trap).
- retired:
  - +1 on the final-cycle exit to FETCH of every instruction, including a not-taken branch.
  - Not incremented on the TRAP path.
  - Wraps modulo 2^CNT_W.
- Timing: single-cycle memAck gives cycle counts of 3 (branch/J/JAL/JR), 4 (R, I, SW) and 5 (LW).

Test Plan:
- Reset mid-MEM_RD with memAck=0 -> next cycle memReq=1, memIn=0 (FETCH), retired=0, no mdrWe.
- ADD with memAck=1 every request -> 4 cycles; WB cycle regWe=1, dst=0, regIn=1; retired 0->1.
- LW with memAck delayed 3 cycles in MEM_RD -> memReq held 4 cycles, mdrWe only in the ack cycle, WB_LW regIn=0, dst=1; total 8 cycles.
- BEQ eq=0 then BNE eq=0 -> first pcWe=0, second pcWe=1 with pcSrc=0; retired +2.
- JAL -> single cycle with pcWe=1, pcSrc=2, regWe=1, dst=2, regIn=2; next FETCH.
- cmd=13 at DECODE -> trap=1, trapCause=1, all enables 0 for 10 cycles. Separately, MEM_TIMEOUT=4 with memAck never asserted in FETCH -> trap after 5 FETCH cycles, trapCause=2.
